// File: rtl/dphy_lane_deskew_pkg.sv
// Shared types and helpers for the D-PHY lane deskew block.
package dphy_lane_deskew_pkg;

    // Deskew controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } deskew_state_t;

    // Width of the ALIGN timeout counter (timeouts up to 255 cycles).
    localparam int unsigned CNT_W = 8;

    // Requested lane count, with 0 or out-of-range meaning "all lanes".
    function automatic int unsigned sat_lanes(input int unsigned req,
                                              input int unsigned max_lanes);
        if (req == 0 || req > max_lanes) begin
            return max_lanes;
        end
        return req;
    endfunction

endpackage

// File: rtl/dphy_lane_deskew_fifo.sv
// Per-lane skew FIFO: byte-wide, depth-parameterised, synchronous clear.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module dphy_skew_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full_o    = (r_count == CW'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign data_o    = r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the count gates reads.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dphy_lane_deskew.sv
// D-PHY lane deskew: buffers each active lane in its own skew FIFO and emits
// a lane-aligned word once every active lane holds at least one byte.
// Handshake: valid_i[l] qualifies byte_data_i lane l for one cycle (no
// backpressure); valid_o qualifies word_o for one cycle.
// dbg_state_o exposes the controller state encoding (IDLE=0 .. FLUSH=3).
module dphy_lane_deskew
    import dphy_lane_deskew_pkg::*;
#(
    parameter int DATA_LANES = 4,
    parameter int SKEW_DEPTH = 4,
    parameter int TIMEOUT    = 8,
    localparam int LW        = $clog2(DATA_LANES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [LW-1:0]           active_lanes_i,
    input  logic [DATA_LANES*8-1:0] byte_data_i,
    input  logic [DATA_LANES-1:0]   valid_i,
    input  logic                    pkt_done_i,
    output logic                    reset_sync_o,
    output logic [DATA_LANES*8-1:0] word_o,
    output logic                    valid_o,
    output logic                    skew_err_o,
    output logic [1:0]              dbg_state_o
);
    deskew_state_t             r_state;
    deskew_state_t             w_next;
    logic [LW-1:0]             r_lanes;
    logic [LW-1:0]             w_lanes_in;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      w_timeout;
    logic [DATA_LANES-1:0]     w_mask_in;
    logic [DATA_LANES-1:0]     w_mask_lat;
    logic [DATA_LANES-1:0]     w_act;
    logic [DATA_LANES-1:0]     w_full;
    logic [DATA_LANES-1:0]     w_empty;
    logic [DATA_LANES-1:0]     w_push;
    logic [DATA_LANES-1:0]     w_pop_lane;
    logic [DATA_LANES*8-1:0]   w_head;
    logic [DATA_LANES*8-1:0]   w_word;
    logic                      w_all_ne;
    logic                      w_any_ne;
    logic                      w_any_valid;
    logic                      w_ovf_raw;
    logic                      w_push_en;
    logic                      w_pop;
    logic                      w_err;
    logic                      w_clear;
    logic                      r_valid;
    logic                      r_err;
    logic                      r_rsync;
    logic [DATA_LANES*8-1:0]   r_word;

    assign w_lanes_in = LW'(sat_lanes(32'(active_lanes_i), DATA_LANES));
    assign w_cnt_nxt  = r_cnt + CNT_W'(1);
    assign w_timeout  = (w_cnt_nxt == CNT_W'(TIMEOUT));

    // Active-lane masks: live request while IDLE, latched count otherwise.
    always_comb begin
        w_mask_in  = '0;
        w_mask_lat = '0;
        for (int l = 0; l < DATA_LANES; l++) begin
            w_mask_in[l]  = (LW'(l) < w_lanes_in);
            w_mask_lat[l] = (LW'(l) < r_lanes);
        end
    end

    assign w_act       = (r_state == ST_IDLE) ? w_mask_in : w_mask_lat;
    assign w_all_ne    = &(~w_empty | ~w_act);
    assign w_any_ne    = |(~w_empty & w_act);
    assign w_any_valid = |(valid_i & w_act);
    assign w_ovf_raw   = |(valid_i & w_act & w_full);
    assign w_push      = valid_i & w_act & {DATA_LANES{w_push_en}};
    assign w_pop_lane  = w_act & {DATA_LANES{w_pop}};
    assign w_clear     = (r_state == ST_FLUSH);

    for (genvar g = 0; g < DATA_LANES; g++) begin : g_lane
        dphy_skew_fifo #(.DEPTH(SKEW_DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (w_clear),
            .push_i  (w_push[g]),
            .pop_i   (w_pop_lane[g]),
            .data_i  (byte_data_i[g*8 +: 8]),
            .data_o  (w_head[g*8 +: 8]),
            .full_o  (w_full[g]),
            .empty_o (w_empty[g])
        );
    end

    // Word assembly: inactive lanes always contribute zero.
    always_comb begin
        w_word = '0;
        for (int l = 0; l < DATA_LANES; l++) begin
            if (w_act[l]) w_word[l*8 +: 8] = w_head[l*8 +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and per-cycle push/pop/error decisions.
    always_comb begin
        w_next    = r_state;
        w_push_en = 1'b0;
        w_pop     = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_push_en = 1'b1;
                    w_next    = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (pkt_done_i) begin
                    w_next = ST_FLUSH;
                end else if (w_all_ne) begin
                    w_pop     = 1'b1;
                    w_push_en = 1'b1;
                    w_next    = ST_STREAM;
                end else if (w_ovf_raw || w_timeout) begin
                    w_err  = 1'b1;
                    w_next = ST_FLUSH;
                end else begin
                    w_push_en = 1'b1;
                end
            end
            ST_STREAM: begin
                if (pkt_done_i) begin
                    w_next = ST_FLUSH;
                end else if (w_all_ne) begin
                    w_pop     = 1'b1;
                    w_push_en = 1'b1;
                end else if (w_ovf_raw) begin
                    w_err  = 1'b1;
                    w_next = ST_FLUSH;
                end else if (!w_any_valid || !w_any_ne) begin
                    w_next = ST_FLUSH;
                end else begin
                    w_push_en = 1'b1;
                end
            end
            ST_FLUSH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Timeout counter and lane-count latch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_lanes <= LW'(DATA_LANES);
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
            if (w_any_valid) r_lanes <= w_lanes_in;
        end else if (r_state == ST_ALIGN) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Registered outputs: word/valid one edge after the pop, single-cycle pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_word  <= '0;
            r_err   <= 1'b0;
            r_rsync <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) r_word <= w_word;
            r_err   <= w_err;
            r_rsync <= (r_state == ST_FLUSH);
        end
    end

    assign valid_o      = r_valid;
    assign word_o       = r_word;
    assign skew_err_o   = r_err;
    assign reset_sync_o = r_rsync;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_dphy_lane_deskew.sv
// Self-checking bench for dphy_lane_deskew: directed scenarios plus random
// bursts, compared every cycle against a queue-based behavioural model.
module tb_dphy_lane_deskew;
    localparam int NL    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    // Model phases (the model's own vocabulary).
    localparam int WAITING   = 0;
    localparam int GATHERING = 1;
    localparam int STREAMING = 2;
    localparam int DRAINING  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  al;
    logic [31:0] bd;
    logic [3:0]  vi;
    logic        done;
    logic        rs;
    logic [31:0] wo;
    logic        vo;
    logic        se;
    logic [1:0]  st;

    int test_cnt = 0;
    int fail_cnt = 0;

    // Behavioural model state.
    int          m_ph;
    int          m_n;
    int          m_cnt;
    logic [7:0]  m_q [NL][$];
    logic        e_valid;
    logic        e_err;
    logic        e_rs;
    logic [31:0] e_word;

    // Per-burst observation counters.
    int g_start [NL];
    int g_len   [NL];
    int g_cyc;
    int g_vo_cnt;
    int g_vo_first;
    int g_err_cnt;
    int g_err_at;
    int g_rs_cnt;
    int g_rs_at;
    int g_hi_nz;

    dphy_lane_deskew #(
        .DATA_LANES (NL),
        .SKEW_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .active_lanes_i (al),
        .byte_data_i    (bd),
        .valid_i        (vi),
        .pkt_done_i     (done),
        .reset_sync_o   (rs),
        .word_o         (wo),
        .valid_o        (vo),
        .skew_err_o     (se),
        .dbg_state_o    (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph    = WAITING;
        m_n     = NL;
        m_cnt   = 0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_rs    = 1'b0;
        e_word  = '0;
        for (int l = 0; l < NL; l++) m_q[l].delete();
    endtask

    task automatic push_lanes(input logic [3:0] v, input logic [31:0] d);
        for (int l = 0; l < m_n; l++) begin
            if (v[l]) m_q[l].push_back(d[l*8 +: 8]);
        end
    endtask

    task automatic emit_word();
        e_word = '0;
        for (int l = 0; l < m_n; l++) e_word[l*8 +: 8] = m_q[l].pop_front();
        e_valid = 1'b1;
    endtask

    // One clock edge of the reference behaviour; expectations are for after the edge.
    task automatic model_step(input logic [3:0] v, input logic [31:0] d,
                              input logic dn, input logic [2:0] a);
        int n_req;
        bit any_v;
        bit ready;
        bit ovf;
        bit all_empty;
        n_req   = (a == 3'd0 || int'(a) > NL) ? NL : int'(a);
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_rs    = 1'b0;
        case (m_ph)
            WAITING: begin
                any_v = 1'b0;
                for (int l = 0; l < n_req; l++) if (v[l]) any_v = 1'b1;
                if (any_v) begin
                    m_n   = n_req;
                    m_cnt = 0;
                    push_lanes(v, d);
                    m_ph  = GATHERING;
                end
            end
            GATHERING, STREAMING: begin
                ready     = 1'b1;
                ovf       = 1'b0;
                any_v     = 1'b0;
                all_empty = 1'b1;
                for (int l = 0; l < m_n; l++) begin
                    if (m_q[l].size() == 0) ready = 1'b0;
                    else                    all_empty = 1'b0;
                    if (v[l]) begin
                        any_v = 1'b1;
                        if (m_q[l].size() == DEPTH) ovf = 1'b1;
                    end
                end
                if (dn) begin
                    m_ph = DRAINING;
                end else if (ready) begin
                    emit_word();
                    push_lanes(v, d);
                    m_ph = STREAMING;
                end else if (m_ph == GATHERING) begin
                    m_cnt++;
                    if (ovf || m_cnt == TMO) begin
                        e_err = 1'b1;
                        m_ph  = DRAINING;
                    end else begin
                        push_lanes(v, d);
                    end
                end else if (ovf) begin
                    e_err = 1'b1;
                    m_ph  = DRAINING;
                end else if (!any_v || all_empty) begin
                    m_ph = DRAINING;
                end else begin
                    push_lanes(v, d);
                end
            end
            default: begin
                for (int l = 0; l < NL; l++) m_q[l].delete();
                e_rs = 1'b1;
                m_ph = WAITING;
            end
        endcase
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 time unit later.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic dn,
                         input string tag);
        vi   = v;
        bd   = d;
        done = dn;
        @(posedge clk);
        model_step(v, d, dn, al);
        #1;
        chk({tag, ".valid_o"}, 32'(vo), 32'(e_valid));
        if (e_valid) chk({tag, ".word_o"}, wo, e_word);
        chk({tag, ".skew_err_o"}, 32'(se), 32'(e_err));
        chk({tag, ".reset_sync_o"}, 32'(rs), 32'(e_rs));
        if (vo) begin
            g_vo_cnt++;
            if (g_vo_first < 0) g_vo_first = g_cyc;
            if (wo[31:16] != 16'h0) g_hi_nz++;
        end
        if (se) begin
            g_err_cnt++;
            if (g_err_at < 0) g_err_at = g_cyc;
        end
        if (rs) begin
            g_rs_cnt++;
            if (g_rs_at < 0) g_rs_at = g_cyc;
        end
        g_cyc++;
    endtask

    // Lane l is valid for cycles [g_start[l], g_start[l]+g_len[l]); then an idle tail.
    task automatic run_burst(input string tag, input int ncyc, input int done_at,
                             input bit noise);
        logic [3:0]  v;
        logic [31:0] d;
        int          n_req;
        n_req      = (al == 3'd0 || int'(al) > NL) ? NL : int'(al);
        g_cyc      = 0;
        g_vo_cnt   = 0;
        g_vo_first = -1;
        g_err_cnt  = 0;
        g_err_at   = -1;
        g_rs_cnt   = 0;
        g_rs_at    = -1;
        g_hi_nz    = 0;
        for (int c = 0; c < ncyc + 12; c++) begin
            v = '0;
            d = $urandom;
            if (c < ncyc) begin
                for (int l = 0; l < NL; l++) begin
                    if (c >= g_start[l] && c < g_start[l] + g_len[l]) v[l] = 1'b1;
                    if (noise && l >= n_req) v[l] = 1'($urandom_range(0, 1));
                end
            end
            cycle(v, d, (c == done_at), tag);
        end
        chk({tag, ".back_to_idle"}, 32'(st), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        al    = 3'd4;
        bd    = '0;
        vi    = '0;
        done  = 1'b0;
        model_reset();
        #2;
        chk("reset.valid_o", 32'(vo), 32'd0);
        chk("reset.word_o", wo, 32'd0);
        chk("reset.skew_err_o", 32'(se), 32'd0);
        chk("reset.reset_sync_o", 32'(rs), 32'd0);
        chk("reset.state", 32'(st), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Zero skew: word appears after the edge following the capture edge.
        cycle(4'hF, 32'h1312_1110, 1'b0, "s1");
        cycle(4'h0, $urandom, 1'b0, "s1");
        chk("s1.first_word", wo, 32'h1312_1110);
        chk("s1.first_valid", 32'(vo), 32'd1);
        for (int i = 0; i < 4; i++) cycle(4'h0, $urandom, 1'b0, "s1_tail");

        // Lane 2 three cycles late, within FIFO depth.
        g_start = '{0, 0, 3, 0};
        g_len   = '{8, 8, 8, 8};
        run_burst("s2", 16, -1, 1'b0);
        chk("s2.err_count", 32'(g_err_cnt), 32'd0);
        chk("s2.first_valid_cycle", 32'(g_vo_first), 32'd4);
        chk("s2.word_count", 32'(g_vo_cnt), 32'd8);

        // Lane 3 five cycles late: the other lanes overflow.
        g_start = '{0, 0, 0, 5};
        g_len   = '{5, 5, 5, 1};
        run_burst("s3", 8, -1, 1'b0);
        chk("s3.err_count", 32'(g_err_cnt), 32'd1);
        chk("s3.err_cycle", 32'(g_err_at), 32'd4);
        chk("s3.rsync_cycle", 32'(g_rs_at), 32'd5);
        chk("s3.rsync_count", 32'(g_rs_cnt), 32'd1);
        chk("s3.word_count", 32'(g_vo_cnt), 32'd0);

        // Lane 1 never valid: timeout after TMO cycles in ALIGN.
        g_start = '{0, 0, 0, 0};
        g_len   = '{3, 0, 3, 3};
        run_burst("s4", 4, -1, 1'b0);
        chk("s4.err_count", 32'(g_err_cnt), 32'd1);
        chk("s4.err_cycle", 32'(g_err_at), 32'd8);
        chk("s4.rsync_cycle", 32'(g_rs_at), 32'd9);
        chk("s4.word_count", 32'(g_vo_cnt), 32'd0);

        // Two-lane mode with noise on lanes 2..3.
        al      = 3'd2;
        g_start = '{0, 1, 0, 2};
        g_len   = '{6, 6, 3, 3};
        run_burst("s5", 10, -1, 1'b1);
        chk("s5.upper_bytes_nonzero", 32'(g_hi_nz), 32'd0);
        chk("s5.word_count", 32'(g_vo_cnt), 32'd6);
        chk("s5.first_valid_cycle", 32'(g_vo_first), 32'd2);

        // pkt_done mid-stream.
        al      = 3'd4;
        g_start = '{0, 0, 0, 0};
        g_len   = '{5, 5, 5, 5};
        run_burst("s6a", 5, 4, 1'b0);
        chk("s6a.word_count", 32'(g_vo_cnt), 32'd3);
        chk("s6a.rsync_count", 32'(g_rs_cnt), 32'd1);
        chk("s6a.err_count", 32'(g_err_cnt), 32'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) cycle(4'hF, $urandom, 1'b0, "s6b_pre");
        #3 rst_n = 1'b0;
        vi = '0;
        #1;
        model_reset();
        chk("s6b.valid_o", 32'(vo), 32'd0);
        chk("s6b.word_o", wo, 32'd0);
        chk("s6b.skew_err_o", 32'(se), 32'd0);
        chk("s6b.reset_sync_o", 32'(rs), 32'd0);
        chk("s6b.state", 32'(st), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        g_len = '{0, 0, 0, 0};
        run_burst("s6b_idle", 0, -1, 1'b0);
        chk("s6b.no_word_after_reset", 32'(g_vo_cnt), 32'd0);
        chk("s6b.no_rsync_after_reset", 32'(g_rs_cnt), 32'd0);
        g_len = '{4, 4, 4, 4};
        run_burst("s6b_after", 4, -1, 1'b0);
        chk("s6b.words_after", 32'(g_vo_cnt), 32'd4);

        // Lane count 0 and out-of-range both mean all lanes.
        al = 3'd0;
        run_burst("n0", 4, -1, 1'b0);
        chk("n0.word_count", 32'(g_vo_cnt), 32'd4);
        al = 3'd7;
        run_burst("n7", 4, -1, 1'b0);
        chk("n7.word_count", 32'(g_vo_cnt), 32'd4);

        // Random bursts against the model.
        for (int i = 0; i < 30; i++) begin
            int dn_at;
            al = 3'($urandom_range(0, 7));
            for (int l = 0; l < NL; l++) begin
                g_start[l] = int'($urandom_range(0, 4));
                g_len[l]   = int'($urandom_range(0, 8));
            end
            dn_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
            run_burst($sformatf("rnd%0d", i), 14, dn_at, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/dphy_lane_deskew.md
DPHY_LANE_DESKEW -- requirements
Module: dphy_lane_deskew

Interface
REQ-001 Parameter DATA_LANES, default 4: number of physical byte lanes, legal 1..4.
REQ-002 Parameter SKEW_DEPTH, default 4: per-lane skew FIFO depth in bytes, legal 2..16.
REQ-003 Parameter TIMEOUT, default 8: maximum cycles in ALIGN before a skew error, legal 1..255.
REQ-004 clk_i  input  1  byte clock; sole clock.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 active_lanes_i  input  clog2(DATA_LANES+1)  runtime lane count; sampled only in IDLE.
REQ-007 byte_data_i  input  DATA_LANES x 8  aligned byte per lane, from the per-lane byte sync.
REQ-008 valid_i  input  DATA_LANES  per-lane byte valid.
REQ-009 pkt_done_i  input  1  end of packet from the packet layer; single-cycle pulse.
REQ-010 reset_sync_o  output  1  one-cycle pulse; re-arms the per-lane byte syncs.
REQ-011 word_o  output  DATA_LANES x 8  deskewed word; lane 0 in bits [7:0].
REQ-012 valid_o  output  1  word_o valid.
REQ-013 skew_err_o  output  1  one-cycle pulse on a skew or timeout failure.

Function
REQ-014 Active lanes: lanes 0..N-1 with N = active_lanes_i, latched on leaving IDLE; N = 0 or N > DATA_LANES is treated as DATA_LANES.
REQ-015 Inactive lanes: valid_i ignored, never written, word_o byte held at 0.
REQ-016 Each active lane pushes byte_data_i into its own SKEW_DEPTH FIFO on every cycle its valid_i = 1, except in IDLE-to-ALIGN transitions as in REQ-018 and in FLUSH.
REQ-017 States: IDLE, ALIGN, STREAM, FLUSH.
REQ-018 IDLE: on any active-lane valid_i = 1, capture the bytes of lanes with valid_i = 1 and go to ALIGN; the timeout counter clears to 0.
REQ-019 ALIGN: the counter increments each cycle; when all active FIFOs are non-empty, go to STREAM and pop in the same cycle.
REQ-020 ALIGN failure: if the counter reaches TIMEOUT, or a push hits a full FIFO, pulse skew_err_o and go to FLUSH.
REQ-021 STREAM: in every cycle where all active FIFOs are non-empty, pop all active lanes together; on the next edge register word_o and set valid_o = 1. Otherwise valid_o = 0.
REQ-022 Latency: the first valid_o follows, by exactly one edge, the edge that captured the latest lane's first byte; with zero skew this is 2 edges after the first valid_i.
REQ-023 Simultaneous push and pop on a full FIFO is legal and is not an overflow; push-while-full without a pop is an overflow.
REQ-024 STREAM overflow: pulse skew_err_o and go to FLUSH.
REQ-025 STREAM end of burst: when every active valid_i = 0 and at least one active FIFO is empty while another is non-empty, go to FLUSH with no error. When all active FIFOs are empty, go to FLUSH.
REQ-026 pkt_done_i = 1 in ALIGN or STREAM goes to FLUSH on the next edge and has priority over pops; in IDLE it is ignored.
REQ-027 FLUSH lasts one cycle: clear all FIFO pointers, set valid_o = 0, pulse reset_sync_o, then return to IDLE.
REQ-028 skew_err_o and reset_sync_o are registered; each pulses for exactly one cycle per event.

Reset
REQ-029 rst_i low asynchronously forces IDLE and empties all FIFOs.
REQ-030 rst_i low asynchronously sets valid_o = 0, word_o = 0, reset_sync_o = 0, skew_err_o = 0, the counter = 0 and the latched lane count = DATA_LANES.
REQ-031 Reset asserted mid-packet discards all buffered bytes; no word is emitted after deassertion until a new IDLE-to-STREAM sequence completes.

Structure
REQ-032 The state enum and the lane-count saturation function live in the shared dphy package.
REQ-033 The per-lane FIFO is a sub-module, dphy_skew_fifo (depth-parameterised; push, pop, full, empty, clear), instantiated DATA_LANES times in a generate loop.

Verification
REQ-034 Scenario 1, zero skew: 4 lanes, bytes 0x10..0x13 on lanes 0..3 with valid at edge 0 -> word_o = 0x13121110 and valid_o = 1 after edge 1.
REQ-035 Scenario 2, skew: lane 2 starts 3 cycles late, SKEW_DEPTH = 4 -> words are lane-aligned, first valid_o after the edge following lane 2's first byte, and skew_err_o stays 0.
REQ-036 Scenario 3, excess skew: lane 3 starts 5 cycles late, SKEW_DEPTH = 4 -> skew_err_o pulses once, then reset_sync_o pulses one cycle later, then IDLE, and no valid_o.
REQ-037 Scenario 4, timeout: lane 1 is never valid, TIMEOUT = 8 -> skew_err_o pulses 8 cycles after ALIGN entry, then FLUSH.
REQ-038 Scenario 5, lane mode: active_lanes_i = 2 while lanes 2..3 toggle valid -> word_o[31:16] = 0, and words are formed from lanes 0..1 only.
REQ-039 Scenario 6, interruptions: pkt_done_i mid-STREAM, and separately rst_i low mid-STREAM -> valid_o = 0 next cycle, FIFOs empty; reset_sync_o pulses for pkt_done_i only.
